// File: rtl/fb_writer.sv
// fb_writer: takes screen-space pixels from a transformation pipeline, queues
// them in a small FIFO and writes each one to a linear framebuffer through a
// three-state IDLE -> CALC -> WRITE sequencer with a MemWe/MemReady handshake.
//
// Optional feature: define FB_WRITER_CLIP_EN to discard pixels outside the
// SCR_W x SCR_H screen in CALC (counted in ClipCnt). Without the macro every
// pixel is written at the truncated linear address and ClipCnt stays 0.
module fb_writer #(
    parameter int SCR_W      = 160,
    parameter int SCR_H      = 120,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic        ENB,
    input  logic [15:0] xAddr,
    input  logic [15:0] yAddr,
    input  logic        Write,
    input  logic [7:0]  PixData,
    output logic [15:0] MemAddr,
    output logic [7:0]  MemData,
    output logic        MemWe,
    input  logic        MemReady,
    output logic        Full,
    output logic        Busy,
    output logic [7:0]  OvfCnt,
    output logic [7:0]  ClipCnt
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam int          EW        = 40;
    localparam logic [15:0] SCR_W_16  = SCR_W[15:0];

    // Reject configurations the address arithmetic and pointers cannot support.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fb_writer: FIFO_DEPTH must be a power of two >= 2");
    end
    if (SCR_W * SCR_H > 65536) begin : g_bad_screen
        $error("fb_writer: SCR_W*SCR_H must not exceed 65536");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    // Saturating 8-bit event counter step.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        sat_inc = (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Row-major framebuffer address; the 16-bit result drops any overflow.
    function automatic logic [15:0] lin_addr(input logic [15:0] x, input logic [15:0] y);
        lin_addr = y * SCR_W_16 + x;
    endfunction

    logic [EW-1:0] fifo_mem_r [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_r;
    logic [AW:0]   rd_ptr_r;
    logic [EW-1:0] head_s;
    logic          empty_s;
    logic          full_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;

    state_t        state_r;
    logic [15:0]   cur_x_r;
    logic [15:0]   cur_y_r;
    logic [7:0]    cur_pix_r;
    logic [15:0]   mem_addr_r;
    logic [7:0]    mem_data_r;
    logic          mem_we_r;
    logic [7:0]    ovf_cnt_r;

    // Pointers carry one extra wrap bit so equal indices can mean full or empty.
    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign head_s  = fifo_mem_r[rd_ptr_r[AW-1:0]];

    // The sequencer takes the head whenever it is idle; a pop frees a slot
    // for a push on the same edge even when the FIFO is full.
    assign pop_s  = (state_r == ST_IDLE) && !empty_s;
    assign push_s = ENB && Write && (!full_s || pop_s);
    assign drop_s = ENB && Write && full_s && !pop_s;

    // FIFO storage: data only, validity is tracked by the pointers.
    always_ff @(posedge ACLK) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r[AW-1:0]] <= {xAddr, yAddr, PixData};
        end
    end

    // FIFO pointers and overflow counter.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            ovf_cnt_r <= 8'd0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (drop_s) begin
                ovf_cnt_r <= sat_inc(ovf_cnt_r);
            end
        end
    end

`ifdef FB_WRITER_CLIP_EN
    logic [7:0] clip_cnt_r;
    logic       clip_s;

    assign clip_s = ({16'd0, cur_x_r} >= SCR_W) || ({16'd0, cur_y_r} >= SCR_H);
    assign ClipCnt = clip_cnt_r;
`else
    assign ClipCnt = 8'd0;
`endif

    // Write sequencer: latch head, compute address, hold request until accepted.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_r    <= ST_IDLE;
            cur_x_r    <= 16'd0;
            cur_y_r    <= 16'd0;
            cur_pix_r  <= 8'd0;
            mem_addr_r <= 16'd0;
            mem_data_r <= 8'd0;
            mem_we_r   <= 1'b0;
`ifdef FB_WRITER_CLIP_EN
            clip_cnt_r <= 8'd0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!empty_s) begin
                        cur_x_r   <= head_s[39:24];
                        cur_y_r   <= head_s[23:8];
                        cur_pix_r <= head_s[7:0];
                        state_r   <= ST_CALC;
                    end
                end
                ST_CALC: begin
`ifdef FB_WRITER_CLIP_EN
                    if (clip_s) begin
                        clip_cnt_r <= sat_inc(clip_cnt_r);
                        state_r    <= ST_IDLE;
                    end else begin
                        mem_addr_r <= lin_addr(cur_x_r, cur_y_r);
                        mem_data_r <= cur_pix_r;
                        mem_we_r   <= 1'b1;
                        state_r    <= ST_WRITE;
                    end
`else
                    mem_addr_r <= lin_addr(cur_x_r, cur_y_r);
                    mem_data_r <= cur_pix_r;
                    mem_we_r   <= 1'b1;
                    state_r    <= ST_WRITE;
`endif
                end
                ST_WRITE: begin
                    if (MemReady) begin
                        mem_we_r <= 1'b0;
                        state_r  <= ST_IDLE;
                    end
                end
                default: begin
                    mem_we_r <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    assign MemAddr = mem_addr_r;
    assign MemData = mem_data_r;
    assign MemWe   = mem_we_r;
    assign OvfCnt  = ovf_cnt_r;
    assign Full    = full_s;
    assign Busy    = !empty_s || (state_r != ST_IDLE);

endmodule

// File: tb/tb_fb_writer.sv
// Self-checking bench for fb_writer: table of single-pixel vectors plus
// hand-written sequences for back-pressure, overflow, reset abort and ENB gating.
module tb_fb_writer;

    logic        ACLK;
    logic        ARESETn;
    logic        ENB;
    logic [15:0] xAddr;
    logic [15:0] yAddr;
    logic        Write;
    logic [7:0]  PixData;
    logic [15:0] MemAddr;
    logic [7:0]  MemData;
    logic        MemWe;
    logic        MemReady;
    logic        Full;
    logic        Busy;
    logic [7:0]  OvfCnt;
    logic [7:0]  ClipCnt;

    int n_cmp = 0;
    int n_err = 0;
    int exp_clip_cnt = 0;

    logic [15:0] q_addr [$];
    logic [7:0]  q_data [$];

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  pix;
        logic [15:0] addr;
    } vec_t;

    vec_t vecs [8];

    fb_writer dut (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .ENB      (ENB),
        .xAddr    (xAddr),
        .yAddr    (yAddr),
        .Write    (Write),
        .PixData  (PixData),
        .MemAddr  (MemAddr),
        .MemData  (MemData),
        .MemWe    (MemWe),
        .MemReady (MemReady),
        .Full     (Full),
        .Busy     (Busy),
        .OvfCnt   (OvfCnt),
        .ClipCnt  (ClipCnt)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Record each accepted memory write; values at the falling edge are the
    // ones the memory sees at the following rising edge.
    always @(negedge ACLK) begin
        if (ARESETn && MemWe && MemReady) begin
            q_addr.push_back(MemAddr);
            q_data.push_back(MemData);
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic do_reset();
        ARESETn  = 1'b0;
        ENB      = 1'b1;
        Write    = 1'b0;
        xAddr    = 16'd0;
        yAddr    = 16'd0;
        PixData  = 8'd0;
        MemReady = 1'b1;
        tick();
        tick();
        ARESETn = 1'b1;
        exp_clip_cnt = 0;
        q_addr.delete();
        q_data.delete();
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 200; c++) begin
            if (!Busy) break;
            tick();
        end
        check({name, "_drained"}, {31'd0, Busy}, 32'd0);
    endtask

    function automatic bit clip_of(input logic [15:0] x, input logic [15:0] y);
`ifdef FB_WRITER_CLIP_EN
        return (x >= 16'd160) || (y >= 16'd120);
`else
        return (x != x) || (y != y);
`endif
    endfunction

    initial begin
        vecs[0] = '{16'd5,     16'd2,     8'hA5, 16'd325};
        vecs[1] = '{16'd0,     16'd0,     8'h00, 16'd0};
        vecs[2] = '{16'd159,   16'd119,   8'hFF, 16'd19199};
        vecs[3] = '{16'd160,   16'd0,     8'h3C, 16'd160};
        vecs[4] = '{16'd0,     16'd1,     8'h11, 16'd160};
        vecs[5] = '{16'd65535, 16'd65535, 8'h5A, 16'd65375};
        vecs[6] = '{16'd7,     16'd200,   8'hC3, 16'd32007};
        vecs[7] = '{16'd100,   16'd50,    8'h81, 16'd8100};

        // Reset state, checked while reset is still asserted.
        ARESETn  = 1'b0;
        ENB      = 1'b0;
        Write    = 1'b0;
        xAddr    = 16'd0;
        yAddr    = 16'd0;
        PixData  = 8'd0;
        MemReady = 1'b0;
        #3;
        check("rst_memwe",   {31'd0, MemWe}, 32'd0);
        check("rst_memaddr", {16'd0, MemAddr}, 32'd0);
        check("rst_memdata", {24'd0, MemData}, 32'd0);
        check("rst_full",    {31'd0, Full}, 32'd0);
        check("rst_busy",    {31'd0, Busy}, 32'd0);
        check("rst_ovf",     {24'd0, OvfCnt}, 32'd0);
        check("rst_clip",    {24'd0, ClipCnt}, 32'd0);
        do_reset();

        // Single pixels, MemReady high: MemWe two cycles after the Write edge.
        for (int i = 0; i < 8; i++) begin
            bit clip;
            clip = clip_of(vecs[i].x, vecs[i].y);
            q_addr.delete();
            q_data.delete();
            xAddr   = vecs[i].x;
            yAddr   = vecs[i].y;
            PixData = vecs[i].pix;
            Write   = 1'b1;
            tick();
            Write = 1'b0;
            tick();
            check($sformatf("v%0d_we_early", i), {31'd0, MemWe}, 32'd0);
            tick();
            if (clip) begin
                exp_clip_cnt++;
                check($sformatf("v%0d_we_clip", i), {31'd0, MemWe}, 32'd0);
                check($sformatf("v%0d_clipcnt", i), {24'd0, ClipCnt}, exp_clip_cnt);
                check($sformatf("v%0d_busy", i), {31'd0, Busy}, 32'd0);
            end else begin
                check($sformatf("v%0d_we", i), {31'd0, MemWe}, 32'd1);
                check($sformatf("v%0d_addr", i), {16'd0, MemAddr}, {16'd0, vecs[i].addr});
                check($sformatf("v%0d_data", i), {24'd0, MemData}, {24'd0, vecs[i].pix});
                tick();
                check($sformatf("v%0d_we_drop", i), {31'd0, MemWe}, 32'd0);
                check($sformatf("v%0d_busy", i), {31'd0, Busy}, 32'd0);
                check($sformatf("v%0d_clipcnt", i), {24'd0, ClipCnt}, exp_clip_cnt);
            end
            check($sformatf("v%0d_nwrites", i), q_addr.size(), clip ? 32'd0 : 32'd1);
        end

        // ENB low: Write ignored, nothing queued.
        do_reset();
        ENB = 1'b0;
        xAddr = 16'd3;
        yAddr = 16'd3;
        PixData = 8'h77;
        Write = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("enb_busy%0d", i), {31'd0, Busy}, 32'd0);
        end
        Write = 1'b0;
        ENB = 1'b1;
        tick();
        tick();
        tick();
        check("enb_memwe", {31'd0, MemWe}, 32'd0);
        check("enb_nwrites", q_addr.size(), 32'd0);

        // Back-pressure: 10 back-to-back Writes, 9 accepted, one overflow.
        do_reset();
        MemReady = 1'b0;
        for (int i = 0; i < 10; i++) begin
            xAddr   = 16'(i);
            yAddr   = 16'd1;
            PixData = 8'h40 + 8'(i);
            Write   = 1'b1;
            tick();
        end
        Write = 1'b0;
        check("bp_full",  {31'd0, Full}, 32'd1);
        check("bp_ovf",   {24'd0, OvfCnt}, 32'd1);
        check("bp_memwe", {31'd0, MemWe}, 32'd1);
        check("bp_addr0", {16'd0, MemAddr}, 32'd160);
        ENB = 1'b0;
        MemReady = 1'b1;
        drain("bp");
        ENB = 1'b1;
        check("bp_nwrites", q_addr.size(), 32'd9);
        for (int i = 0; i < 9; i++) begin
            if (i < q_addr.size()) begin
                check($sformatf("bp_addr%0d", i), {16'd0, q_addr[i]}, 32'd160 + i);
                check($sformatf("bp_data%0d", i), {24'd0, q_data[i]}, 32'h40 + i);
            end
        end
        check("bp_ovf_end", {24'd0, OvfCnt}, 32'd1);

        // Full FIFO with a pop and a push on the same edge.
        do_reset();
        MemReady = 1'b0;
        for (int i = 0; i < 9; i++) begin
            xAddr   = 16'd20 + 16'(i);
            yAddr   = 16'd3;
            PixData = 8'h80 + 8'(i);
            Write   = 1'b1;
            tick();
        end
        Write = 1'b0;
        check("pp_full_a", {31'd0, Full}, 32'd1);
        MemReady = 1'b1;
        tick();
        check("pp_full_b", {31'd0, Full}, 32'd1);
        xAddr   = 16'd50;
        yAddr   = 16'd3;
        PixData = 8'hEE;
        Write   = 1'b1;
        tick();
        Write = 1'b0;
        check("pp_full_c", {31'd0, Full}, 32'd1);
        check("pp_ovf", {24'd0, OvfCnt}, 32'd0);
        drain("pp");
        check("pp_nwrites", q_addr.size(), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < q_addr.size()) begin
                check($sformatf("pp_addr%0d", i), {16'd0, q_addr[i]},
                      (i < 9) ? 32'd500 + i : 32'd530);
                check($sformatf("pp_data%0d", i), {24'd0, q_data[i]},
                      (i < 9) ? 32'h80 + i : 32'hEE);
            end
        end

        // Reset while in WRITE with three pixels queued: write abandoned.
        do_reset();
        MemReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            xAddr   = 16'd10 + 16'(i);
            yAddr   = 16'd0;
            PixData = 8'h20 + 8'(i);
            Write   = 1'b1;
            tick();
        end
        Write = 1'b0;
        check("ra_memwe_pre", {31'd0, MemWe}, 32'd1);
        check("ra_busy_pre",  {31'd0, Busy}, 32'd1);
        #2;
        ARESETn = 1'b0;
        #1;
        check("ra_memwe",   {31'd0, MemWe}, 32'd0);
        check("ra_busy",    {31'd0, Busy}, 32'd0);
        check("ra_memaddr", {16'd0, MemAddr}, 32'd0);
        tick();
        ARESETn  = 1'b1;
        MemReady = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        check("ra_nwrites", q_addr.size(), 32'd0);
        check("ra_busy_post", {31'd0, Busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fb_writer.md
FB_WRITER -- requirements
Module: fb_writer

Interface
REQ-001 SHALL have parameter SCR_W, default 160: screen width in pixels.
REQ-002 SHALL have parameter SCR_H, default 120: screen height in pixels; SCR_W*SCR_H <= 65536.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8: pixel FIFO entries, power of two, >= 2.
REQ-004 SHALL have port ACLK, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port ARESETn, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port ENB, input, 1: input enable; Write is ignored while low.
REQ-007 SHALL have port xAddr, input, 16: screen X of the pixel from the transformation pipeline.
REQ-008 SHALL have port yAddr, input, 16: screen Y of the pixel.
REQ-009 SHALL have port Write, input, 1: pixel-valid strobe, one pixel per high cycle.
REQ-010 SHALL have port PixData, input, 8: pixel colour, sampled with Write.
REQ-011 SHALL have port MemAddr, output, 16: linear framebuffer address.
REQ-012 SHALL have port MemData, output, 8: framebuffer write data.
REQ-013 SHALL have port MemWe, output, 1: write request; held until accepted.
REQ-014 SHALL have port MemReady, input, 1: memory accepts when MemWe && MemReady at a rising edge.
REQ-015 SHALL have port Full, output, 1: FIFO holds FIFO_DEPTH entries.
REQ-016 SHALL have port Busy, output, 1: FIFO not empty or FSM not IDLE.
REQ-017 SHALL have port OvfCnt, output, 8: count of pixels dropped on a full FIFO.
REQ-018 SHALL have port ClipCnt, output, 8: count of pixels dropped by clipping.

Function
REQ-019 SHALL push {xAddr, yAddr, PixData} into the FIFO on an edge with ENB && Write && (not Full, or a pop in the same cycle).
REQ-020 SHALL drop a pixel offered with ENB && Write while Full and no pop occurs, and increment OvfCnt, saturating at 255.
REQ-021 SHALL run FSM states IDLE, CALC, WRITE; IDLE->CALC when the FIFO is non-empty, popping the head on that edge.
REQ-022 SHALL, in CALC, register MemAddr = yAddr*SCR_W + xAddr truncated to 16 bits, register MemData = PixData, then go to WRITE.
REQ-023 SHALL assert MemWe only in WRITE, hold MemAddr/MemData stable while in WRITE, and leave WRITE for IDLE on the edge where MemReady is high.
REQ-024 SHALL reach MemWe = 1 two cycles after the Write edge when the FIFO is empty and the FSM is IDLE; sustained throughput is one pixel per 3 cycles with MemReady tied high.
REQ-025 SHALL keep draining the FIFO and the FSM while ENB is low; ENB gates the input side only.
REQ-026 SHALL keep FIFO order; pixels reach memory in Write order.
REQ-027 SHALL wrap FIFO pointers modulo FIFO_DEPTH, with one extra bit used to tell full from empty.

Reset
REQ-028 SHALL, on ARESETn low at any time, immediately empty the FIFO, force IDLE, and clear MemWe, MemAddr, MemData, OvfCnt and ClipCnt to 0; Full = 0, Busy = 0.
REQ-029 SHALL abandon without retry a memory write in progress when reset is asserted.

Configuration
REQ-030 SHALL, with macro FB_WRITER_CLIP_EN defined, compare in CALC: when xAddr >= SCR_W or yAddr >= SCR_H, go to IDLE without a WRITE cycle and increment ClipCnt, saturating at 255.
REQ-031 SHALL, without FB_WRITER_CLIP_EN, write every popped pixel using the REQ-022 truncated address, and hold ClipCnt at 0.

Verification
REQ-032 SHALL cover: reset, then one Write with x=5, y=2, PixData=0xA5 and MemReady=1 -> MemWe high 2 cycles later with MemAddr=325 and MemData=0xA5, for one cycle.
REQ-033 SHALL cover: MemReady=0, then 10 back-to-back Writes -> 9 accepted (8 in the FIFO and 1 in the FSM), Full=1, OvfCnt=1; after MemReady=1, exactly 9 writes in order.
REQ-034 SHALL cover: with FB_WRITER_CLIP_EN defined, Write x=160, y=0 -> no MemWe and ClipCnt=1; without the macro -> MemAddr=160.
REQ-035 SHALL cover: Write while ENB=0 -> nothing is pushed and Busy stays 0.
REQ-036 SHALL cover: ARESETn pulsed low while in WRITE with 3 entries queued -> MemWe drops at once, Busy=0, and no further writes occur.
REQ-037 SHALL cover: Full with a pop and a push on the same edge -> the push is accepted and OvfCnt is unchanged.
